reg_file_sb: RTL and testbench

- Parametrised successor to the base integer register file: XLEN-wide, 2**AW-entry register array, two asynchronous read ports and one synchronous write port.
- Adds a per-register pending-write scoreboard. Decode issues destination reservations; writeback retires them.
- Read ports report busy status, and a flush clears all reservations.
- Sits between decode (read/issue) and writeback (write) in the pipelined core.

---
 rtl/reg_file_sb.sv | 143 ++++++++++++++
 tb/tb_reg_file_sb.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
//   Integer register file with a per-register pending-write scoreboard.
//   The array has 2**AW entries of XLEN bits. It provides two combinational
//   read ports and one write port that writes on the clock edge. Entry 0 always
//   reads as zero.
//   Decode reserves a destination with issue. Writeback retires the reservation
//   with a write. A flush clears every reservation.
//
// Optional build:
//   REGFILE_BYPASS_EN - forwards a same-cycle writeback to the read ports.
//                       It also hides busy when that writeback retires the
//                       last outstanding reservation.
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   i_re                        read enable; low forces both read data outputs to 0
//   i_rs1, i_rs2                read addresses
//   o_read_data1/2              read data (combinational)
//   o_rs1_busy/o_rs2_busy       source register has an outstanding write
//   i_issue_valid, i_issue_rd   decode reserves destination i_issue_rd
//   o_issue_ready               the reservation can be accepted this cycle
//   i_wr, i_rd, i_write_data    writeback port
//   i_flush                     clear all reservations
//   o_err_underflow             sticky: a writeback retired a register with no reservation
// -----------------------------------------------------------------------------
module reg_file_sb #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int PEND_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_re,
  input  logic [AW-1:0]   i_rs1,
  input  logic [AW-1:0]   i_rs2,
  output logic [XLEN-1:0] o_read_data1,
  output logic [XLEN-1:0] o_read_data2,
  output logic            o_rs1_busy,
  output logic            o_rs2_busy,
  input  logic            i_issue_valid,
  input  logic [AW-1:0]   i_issue_rd,
  output logic            o_issue_ready,
  input  logic            i_wr,
  input  logic [AW-1:0]   i_rd,
  input  logic [XLEN-1:0] i_write_data,
  input  logic            i_flush,
  output logic            o_err_underflow
);

  localparam int NREG = 2 ** AW;
  localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};

  // Entry 0 of both arrays is reset to zero and never written again.
  logic [XLEN-1:0]   mem [NREG];
  logic [PEND_W-1:0] cnt [NREG];

  logic [NREG-1:0] inc;
  logic [NREG-1:0] dec;
  logic            wr_live;

  assign wr_live = i_wr && (i_rd != '0);

  // ---------------------------------------------------------------------------
  // Read ports and busy status
  // ---------------------------------------------------------------------------
  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] rs);
    logic [XLEN-1:0] data;
    data = '0;
    if (i_re && (rs != '0)) begin
      data = mem[rs];
`ifdef REGFILE_BYPASS_EN
      if (wr_live && (i_rd == rs)) data = i_write_data;
`endif
    end
    return data;
  endfunction

  function automatic logic busy_port(input logic [AW-1:0] rs);
    logic busy;
    busy = i_re && (rs != '0) && (cnt[rs] != '0);
`ifdef REGFILE_BYPASS_EN
    // The final outstanding write is landing on this edge, so the forwarded
    // data is already the value the consumer is waiting for.
    if (wr_live && (i_rd == rs) && (cnt[rs] == PEND_W'(1))) busy = 1'b0;
`endif
    return busy;
  endfunction

  assign o_read_data1 = read_port(i_rs1);
  assign o_read_data2 = read_port(i_rs2);
  assign o_rs1_busy   = busy_port(i_rs1);
  assign o_rs2_busy   = busy_port(i_rs2);

  // A saturated counter can still take a new reservation when a writeback to
  // the same register retires one in the same cycle; the count stays unchanged.
  assign o_issue_ready = (i_issue_rd == '0)
                      || (cnt[i_issue_rd] != CNT_MAX)
                      || (i_wr && (i_rd == i_issue_rd));

  // ---------------------------------------------------------------------------
  // Per-register increment/decrement strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default every combinational output before the loop so no path leaves it unassigned (no latch).
    inc = '0;
    dec = '0;
    for (int r = 1; r < NREG; r++) begin
      inc[r] = i_issue_valid && o_issue_ready && (i_issue_rd == AW'(r));
      dec[r] = i_wr && (i_rd == AW'(r));
    end
  end

  // ---------------------------------------------------------------------------
  // Array, scoreboard counters, sticky underflow flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array must be reset because the architectural state has to read 0 after reset; it cannot be mapped to RAM.
      for (int r = 0; r < NREG; r++) begin
        mem[r] <= '0;
        cnt[r] <= '0;
      end
      o_err_underflow <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every read above sees pre-edge state.
      // A flush does not cancel the array write; the data still lands.
      if (wr_live) mem[i_rd] <= i_write_data;

      for (int r = 1; r < NREG; r++) begin
        if (i_flush) begin
          cnt[r] <= '0;
        end else if (inc[r] && !dec[r]) begin
          cnt[r] <= cnt[r] + PEND_W'(1);
        end else if (!inc[r] && dec[r]) begin
          if (cnt[r] != '0) cnt[r] <= cnt[r] - PEND_W'(1);
          else              o_err_underflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_sb
//   Directed self-checking bench for reg_file_sb with the default parameters
//   (XLEN=32, AW=5, PEND_W=2). Expectations for the same-cycle forwarding step
//   follow the REGFILE_BYPASS_EN define.
// -----------------------------------------------------------------------------
module tb_reg_file_sb;

  logic        clk;
  logic        rst_n;
  logic        i_re;
  logic [4:0]  i_rs1, i_rs2;
  logic [31:0] o_read_data1, o_read_data2;
  logic        o_rs1_busy, o_rs2_busy;
  logic        i_issue_valid;
  logic [4:0]  i_issue_rd;
  logic        o_issue_ready;
  logic        i_wr;
  logic [4:0]  i_rd;
  logic [31:0] i_write_data;
  logic        i_flush;
  logic        o_err_underflow;

  int checks = 0;
  int errors = 0;

  reg_file_sb #(.XLEN(32), .AW(5), .PEND_W(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_re           (i_re),
    .i_rs1          (i_rs1),
    .i_rs2          (i_rs2),
    .o_read_data1   (o_read_data1),
    .o_read_data2   (o_read_data2),
    .o_rs1_busy     (o_rs1_busy),
    .o_rs2_busy     (o_rs2_busy),
    .i_issue_valid  (i_issue_valid),
    .i_issue_rd     (i_issue_rd),
    .o_issue_ready  (o_issue_ready),
    .i_wr           (i_wr),
    .i_rd           (i_rd),
    .i_write_data   (i_write_data),
    .i_flush        (i_flush),
    .o_err_underflow(o_err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Let the inputs settle, then move to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_issue_valid = 1'b0;
    i_wr          = 1'b0;
    i_flush       = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; i_re = 1'b1; i_rs1 = 5'd5; i_rs2 = 5'd31;
    i_issue_valid = 1'b0; i_issue_rd = '0; i_wr = 1'b0; i_rd = '0;
    i_write_data = '0; i_flush = 1'b0;

    // ---- reset ----
    #12;
    check("rst_data1", o_read_data1, 32'h0);
    check("rst_ready", o_issue_ready, 1'b1);
    rst_n = 1'b1;
    cyc();
    check("post_rst_data1", o_read_data1, 32'h0);
    check("post_rst_data2", o_read_data2, 32'h0);
    check("post_rst_busy1", o_rs1_busy, 1'b0);
    check("post_rst_busy2", o_rs2_busy, 1'b0);
    check("post_rst_err", o_err_underflow, 1'b0);

    // ---- reserve x7, then write it; same-cycle read shows old value unless forwarding ----
    i_issue_valid = 1'b1; i_issue_rd = 5'd7;
    cyc();
    idle();
    i_rs1 = 5'd7;
    #1;
    check("x7_busy_after_issue", o_rs1_busy, 1'b1);
    i_wr = 1'b1; i_rd = 5'd7; i_write_data = 32'hDEADBEEF;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("x7_same_cycle", o_read_data1, 32'hDEADBEEF);
`else
    check("x7_same_cycle", o_read_data1, 32'h0);
`endif
    cyc();
    idle();
    #1;
    check("x7_read", o_read_data1, 32'hDEADBEEF);
    check("x7_busy_cleared", o_rs1_busy, 1'b0);

    // ---- writes to x0 are ignored ----
    i_wr = 1'b1; i_rd = 5'd0; i_write_data = 32'h1;
    cyc();
    idle();
    i_rs2 = 5'd0;
    #1;
    check("x0_read", o_read_data2, 32'h0);
    check("x0_busy", o_rs2_busy, 1'b0);
    check("err_still_clear", o_err_underflow, 1'b0);

    // ---- issue to x0: always ready and never counted ----
    i_issue_valid = 1'b1; i_issue_rd = 5'd0;
    #1;
    check("x0_issue_ready", o_issue_ready, 1'b1);
    cyc();
    idle();

    // ---- saturation of x3 ----
    i_rs1 = 5'd3;
    for (int k = 0; k < 3; k++) begin
      i_issue_valid = 1'b1; i_issue_rd = 5'd3;
      #1;
      check("x3_ready_fill", o_issue_ready, 1'b1);
      cyc();
    end
    #1;
    check("x3_busy_sat", o_rs1_busy, 1'b1);
    check("x3_ready_sat", o_issue_ready, 1'b0);
    cyc();  // fourth issue, dropped
    i_wr = 1'b1; i_rd = 5'd3; i_write_data = 32'h31;
    #1;
    check("x3_ready_with_wb", o_issue_ready, 1'b1);
    cyc();  // issue and retire together: count stays 3
    idle();
    i_issue_rd = 5'd3;
    #1;
    check("x3_ready_still_sat", o_issue_ready, 1'b0);
    check("x3_data_wb1", o_read_data1, 32'h31);
    i_wr = 1'b1; i_rd = 5'd3; i_write_data = 32'h32;
    cyc();
    i_write_data = 32'h33;
    cyc();
    i_wr = 1'b0;
    #1;
    check("x3_busy_one_left", o_rs1_busy, 1'b1);
    i_wr = 1'b1; i_write_data = 32'h34;
    cyc();
    i_wr = 1'b0;
    #1;
    check("x3_busy_drained", o_rs1_busy, 1'b0);
    check("x3_data_final", o_read_data1, 32'h34);
    check("x3_no_underflow", o_err_underflow, 1'b0);

    // ---- underflow on x9 ----
    i_wr = 1'b1; i_rd = 5'd9; i_write_data = 32'h99;
    cyc();
    idle();
    i_rs2 = 5'd9;
    #1;
    check("underflow_set", o_err_underflow, 1'b1);
    check("underflow_data", o_read_data2, 32'h99);
    cyc();
    cyc();
    check("underflow_sticky", o_err_underflow, 1'b1);

    // ---- flush with a same-cycle write to x4 and an issue to x5 ----
    i_issue_valid = 1'b1; i_issue_rd = 5'd4;
    cyc();
    cyc();
    idle();
    i_rs1 = 5'd4; i_rs2 = 5'd5;
    #1;
    check("x4_busy_pre_flush", o_rs1_busy, 1'b1);
    i_flush = 1'b1; i_wr = 1'b1; i_rd = 5'd4; i_write_data = 32'h55;
    i_issue_valid = 1'b1; i_issue_rd = 5'd5;
    cyc();
    idle();
    #1;
    check("x4_busy_post_flush", o_rs1_busy, 1'b0);
    check("x4_data_post_flush", o_read_data1, 32'h55);
    check("x5_issue_not_counted", o_rs2_busy, 1'b0);

    // ---- same-cycle writeback to x12 with a single reservation ----
    i_issue_valid = 1'b1; i_issue_rd = 5'd12;
    cyc();
    idle();
    i_rs1 = 5'd12;
    i_wr = 1'b1; i_rd = 5'd12; i_write_data = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("x12_fwd_data", o_read_data1, 32'hA5A5A5A5);
    check("x12_fwd_busy", o_rs1_busy, 1'b0);
`else
    check("x12_old_data", o_read_data1, 32'h0);
    check("x12_old_busy", o_rs1_busy, 1'b1);
`endif
    cyc();
    idle();
    #1;
    check("x12_data_next", o_read_data1, 32'hA5A5A5A5);
    check("x12_busy_next", o_rs1_busy, 1'b0);

    // ---- read enable low forces zero and clears busy ----
    i_issue_valid = 1'b1; i_issue_rd = 5'd7;
    cyc();
    idle();
    i_rs1 = 5'd7; i_re = 1'b0;
    #1;
    check("re_low_data", o_read_data1, 32'h0);
    check("re_low_busy", o_rs1_busy, 1'b0);
    i_re = 1'b1;
    #1;
    check("re_high_busy", o_rs1_busy, 1'b1);

    // ---- asynchronous reset mid-cycle ----
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_data", o_read_data1, 32'h0);
    check("async_rst_busy", o_rs1_busy, 1'b0);
    check("async_rst_err", o_err_underflow, 1'b0);
    i_rs2 = 5'd4;
    #1;
    check("async_rst_x4", o_read_data2, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
